register: RTL and testbench

Single-stage valid/ready pipeline register that breaks the timing path between an upstream stream master (A side) and a downstream stream slave (B side). It carries a WIDTH-bit payload with a one-cycle forward latency and registered handshake outputs, so no combinational path exists from any input to any output. It is the standard buffering element in front of stream consumers such as result sinks and memory writers.

---
 rtl/register_pkg.sv | 28 ++
 rtl/register_stream_reg_slot.sv | 46 ++++
 rtl/register.sv | 136 +++++++++++++
 tb/tb_register.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
// ----------------------------------------------------------------------------
// register_pkg
// Shared definitions for the "register" valid/ready pipeline stage:
//   - BURST_YES / BURST_NO : string values accepted by the BURST parameter
//   - occ_e                : occupancy encoding (EMPTY, ONE, TWO)
//   - occ_from_valids      : maps the two slot valid flags onto occ_e
// No ports (package).
// ----------------------------------------------------------------------------
package register_pkg;

  localparam string BURST_YES = "yes";
  localparam string BURST_NO  = "no";

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  function automatic occ_e occ_from_valids(input logic main_v, input logic skid_v);
    case ({main_v, skid_v})
      2'b00:        return EMPTY;
      2'b10, 2'b01: return ONE;
      default:      return TWO;
    endcase
  endfunction

endpackage

// File: rtl/register_stream_reg_slot.sv
// ----------------------------------------------------------------------------
// stream_reg_slot
// One storage slot of a stream buffer: a valid flag plus a WIDTH-bit payload.
// Load has priority over clear, so a slot can be drained and refilled in the
// same cycle.
//
// Ports:
//   iCLK     in   clock, rising edge
//   iRST     in   asynchronous reset, active low (valid and data cleared)
//   i_load   in   capture i_data and set valid
//   i_clear  in   drop valid (ignored when i_load is high)
//   i_data   in   WIDTH  payload to capture
//   o_valid  out  slot holds a word
//   o_data   out  WIDTH  stored payload
// ----------------------------------------------------------------------------
module stream_reg_slot #(
  parameter int WIDTH = 8
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/register.sv
// ----------------------------------------------------------------------------
// register
// Single-stage valid/ready pipeline register. Every output comes straight
// from a flop, so no combinational path exists from any input to any output.
//   BURST = "yes" : main slot + skid slot, one word per cycle sustained.
//   BURST = other : single slot, one word every two cycles.
//
// Parameters: WIDTH (payload bits, >= 1), BURST ("yes" / "no").
// Ports:
//   iCLK       in   clock, rising edge
//   iRST       in   asynchronous reset, active low; discards buffered words
//   iValid_AM  in   upstream word valid
//   oReady_AM  out  block accepts a word this cycle (registered)
//   iData_AM   in   WIDTH  upstream payload
//   oValid_BM  out  output word valid (registered)
//   iReady_BM  in   downstream accepts the output word
//   oData_BM   out  WIDTH  output payload (registered)
//
// Optional build macro: REGISTER_ASSERT_EN compiles in simulation-only
// protocol / occupancy / X checks. Function is identical without it.
// ----------------------------------------------------------------------------
module register
  import register_pkg::*;
#(
  parameter int    WIDTH = 8,
  parameter string BURST = "yes"
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_AM,
  output logic             oReady_AM,
  input  logic [WIDTH-1:0] iData_AM,
  output logic             oValid_BM,
  input  logic             iReady_BM,
  output logic [WIDTH-1:0] oData_BM
);

  localparam bit BURST_EN = (BURST == BURST_YES);

  logic             r_ready;
  logic             w_a_xfer;
  logic             w_b_xfer;
  logic             w_main_v;
  logic             w_main_load;
  logic             w_main_clear;
  logic [WIDTH-1:0] w_main_din;
  logic [WIDTH-1:0] w_main_dout;
  logic             w_skid_v;
  logic             w_ready_next;

  assign w_a_xfer = iValid_AM && r_ready;
  assign w_b_xfer = w_main_v && iReady_BM;

  stream_reg_slot #(.WIDTH(WIDTH)) u_main (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_din),
    .o_valid (w_main_v),
    .o_data  (w_main_dout)
  );

  generate
    if (BURST_EN) begin : g_burst
      logic             w_main_free;
      logic             w_skid_load;
      logic             w_skid_clear;
      logic [WIDTH-1:0] w_skid_dout;

      stream_reg_slot #(.WIDTH(WIDTH)) u_skid (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (iData_AM),
        .o_valid (w_skid_v),
        .o_data  (w_skid_dout)
      );

      // Main can take a word when it is empty or being drained this edge.
      assign w_main_free  = !w_main_v || w_b_xfer;
      // The skid word is older than anything on the input, so it goes first.
      // The input is never accepted while the skid is full (ready is low).
      assign w_main_load  = w_main_free && (w_skid_v || w_a_xfer);
      assign w_main_din   = w_skid_v ? w_skid_dout : iData_AM;
      assign w_main_clear = w_b_xfer;
      assign w_skid_load  = w_a_xfer && !w_main_free;
      assign w_skid_clear = w_skid_v && w_main_free;
      // Ready for the next cycle is simply "skid will be empty".
      assign w_ready_next = !(w_skid_load || (w_skid_v && !w_skid_clear));
    end else begin : g_single
      assign w_skid_v     = 1'b0;
      // r_ready is only high while the slot is empty, so an accept never
      // overwrites a held word.
      assign w_main_load  = w_a_xfer;
      assign w_main_din   = iData_AM;
      assign w_main_clear = w_b_xfer;
      // Ready follows "slot will be empty"; a drain at edge N re-opens the
      // input for edge N+1 at the earliest.
      assign w_ready_next = !(w_main_load || (w_main_v && !w_b_xfer));
    end
  endgenerate

  // Held low during reset; the first edge after release raises it because
  // both slots are empty at that point.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= w_ready_next;
    end
  end

  assign oReady_AM = r_ready;
  assign oValid_BM = w_main_v;
  assign oData_BM  = w_main_dout;

`ifdef REGISTER_ASSERT_EN
  occ_e w_occ;
  assign w_occ = occ_from_valids(w_main_v, w_skid_v);

  a_hold_data : assert property (@(posedge iCLK) disable iff (!iRST)
      (iValid_AM && !oReady_AM) |=> (iValid_AM && $stable(iData_AM)))
    else $error("register: iValid_AM dropped or iData_AM changed while stalled");

  a_capacity : assert property (@(posedge iCLK) disable iff (!iRST)
      (BURST_EN ? (w_occ <= TWO) : (w_occ <= ONE)))
    else $error("register: occupancy exceeds capacity");

  a_no_x : assert property (@(posedge iCLK) disable iff (!iRST)
      !$isunknown({iValid_AM, iReady_BM}))
    else $error("register: X on iValid_AM/iReady_BM");
`endif

endmodule

// File: tb/tb_register.sv
module tb_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // DUT0: BURST "yes", WIDTH 8 / DUT1: BURST "no", WIDTH 8 / DUT2: "yes", WIDTH 1
  logic       v0, rb0, rdy0, ov0;
  logic [7:0] d0, od0;
  logic       v1, rb1, rdy1, ov1;
  logic [7:0] d1, od1;
  logic       v2, rb2, rdy2, ov2;
  logic [0:0] d2, od2;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: each configuration is an order-preserving FIFO of the
  // words it accepted; outputs must come out in exactly that order.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int acc0 = 0, acc1 = 0, acc2 = 0;
  int out0 = 0, out1 = 0, out2 = 0;

  register #(.WIDTH(8), .BURST("yes")) u_yes (
    .iCLK(clk), .iRST(rst_n), .iValid_AM(v0), .oReady_AM(rdy0), .iData_AM(d0),
    .oValid_BM(ov0), .iReady_BM(rb0), .oData_BM(od0));

  register #(.WIDTH(8), .BURST("no")) u_no (
    .iCLK(clk), .iRST(rst_n), .iValid_AM(v1), .oReady_AM(rdy1), .iData_AM(d1),
    .oValid_BM(ov1), .iReady_BM(rb1), .oData_BM(od1));

  register #(.WIDTH(1), .BURST("yes")) u_w1 (
    .iCLK(clk), .iRST(rst_n), .iValid_AM(v2), .oReady_AM(rdy2), .iData_AM(d2),
    .oValid_BM(ov2), .iReady_BM(rb2), .oData_BM(od2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int outcnt(input int k);
    case (k)
      0:       return out0;
      1:       return out1;
      default: return out2;
    endcase
  endfunction

  function automatic int acccnt(input int k);
    case (k)
      0:       return acc0;
      1:       return acc1;
      default: return acc2;
    endcase
  endfunction

  // Monitors: sample after the falling edge, pop and compare on each B transfer.
  always begin
    @(negedge clk); #2;
    if (rst_n === 1'b1 && ov0 === 1'b1 && rb0 === 1'b1) begin
      out0++;
      check("yes_out_expected", (q0.size() > 0), 1);
      if (q0.size() > 0) check("yes_data", {24'b0, od0}, {24'b0, q0.pop_front()});
    end
  end

  always begin
    @(negedge clk); #2;
    if (rst_n === 1'b1 && ov1 === 1'b1 && rb1 === 1'b1) begin
      out1++;
      check("no_out_expected", (q1.size() > 0), 1);
      if (q1.size() > 0) check("no_data", {24'b0, od1}, {24'b0, q1.pop_front()});
    end
  end

  always begin
    @(negedge clk); #2;
    if (rst_n === 1'b1 && ov2 === 1'b1 && rb2 === 1'b1) begin
      out2++;
      check("w1_out_expected", (q2.size() > 0), 1);
      if (q2.size() > 0) check("w1_data", {31'b0, od2}, {24'b0, q2.pop_front()});
    end
  end

  // Drive one cycle on DUT k (called at a falling edge, returns at the next).
  // A transfer happens at the coming rising edge when valid && ready.
  task automatic step(input int k, input logic v, input logic [7:0] d,
                      input logic rb, output logic acc);
    acc = 1'b0;
    case (k)
      0: begin
        v0 = v; d0 = d; rb0 = rb;
        acc = v && rdy0 && rst_n;
        if (acc) begin q0.push_back(d); acc0++; end
      end
      1: begin
        v1 = v; d1 = d; rb1 = rb;
        acc = v && rdy1 && rst_n;
        if (acc) begin q1.push_back(d); acc1++; end
      end
      default: begin
        v2 = v; d2 = d[0]; rb2 = rb;
        acc = v && rdy2 && rst_n;
        if (acc) begin q2.push_back({7'b0, d[0]}); acc2++; end
      end
    endcase
    @(negedge clk);
  endtask

  task automatic drain(input int k);
    logic a;
    int   n = 0;
    while (qsize(k) != 0 && n < 64) begin
      step(k, 1'b0, 8'h00, 1'b1, a);
      n++;
    end
    repeat (2) step(k, 1'b0, 8'h00, 1'b1, a);
    check($sformatf("drain%0d_empty", k), qsize(k), 0);
    check($sformatf("drain%0d_count", k), outcnt(k), acccnt(k));
  endtask

  // Random handshakes; the source holds valid/data until accepted.
  task automatic rand_run(input int k, input int nwords, input int budget);
    int         sent = 0;
    int         used = 0;
    logic       pend = 1'b0;
    logic       v = 1'b0;
    logic       acc;
    logic [7:0] dat = 8'h00;
    while (sent < nwords && used < budget) begin
      if (!pend) begin
        v   = 1'($urandom_range(0, 1));
        dat = 8'($urandom_range(0, 255));
      end
      step(k, v, dat, 1'($urandom_range(0, 1)), acc);
      if (acc) sent++;
      pend = v && !acc;
      used++;
    end
    check($sformatf("rand%0d_sent", k), sent, nwords);
    drain(k);
    $display("random run dut%0d: %0d words in %0d cycles", k, sent, used);
  endtask

  initial begin
    logic acc;
    int   idx;
    int   cnt;
    int   cnt2;

    rst_n = 1'b0;
    v0 = 0; d0 = 0; rb0 = 0;
    v1 = 0; d1 = 0; rb1 = 0;
    v2 = 0; d2 = 0; rb2 = 0;

    // Reset state and release
    repeat (3) @(negedge clk);
    check("rst_valid", ov0, 0);
    check("rst_data", od0, 0);
    check("rst_ready", rdy0, 0);
    check("rst_no_ready", rdy1, 0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", rdy0, 0);
    @(negedge clk);
    check("ready_after_edge", rdy0, 1);
    check("no_ready_after_edge", rdy1, 1);
    check("w1_ready_after_edge", rdy2, 1);

    // "yes" streaming 0..255, both sides always ready
    idx = 0; cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0 && ov0 === 1'b1 && od0 === 8'(i - 1)) cnt++;
      step(0, 1'b1, 8'(i), 1'b1, acc);
      if (acc) idx++;
      if (i == 0) begin
        check("stream_first_valid", ov0, 1);
        check("stream_first_data", od0, 0);
      end
    end
    check("stream_accepts", idx, 256);
    check("stream_rate", cnt, 255);
    step(0, 1'b0, 8'h00, 1'b1, acc);
    check("stream_outputs", out0, 256);
    drain(0);
    $display("streaming: %0d words out", out0);

    // "yes" stall: iReady_BM low for 5 cycles mid-stream
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b1, 8'(64 + idx), 1'b1, acc);
      if (acc) idx++;
    end
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 5; i++) begin
      if (rdy0 === 1'b0) cnt2++;
      step(0, 1'b1, 8'(64 + idx), 1'b0, acc);
      if (acc) begin idx++; cnt++; end
    end
    check("stall_skid_words", cnt, 1);
    check("stall_ready_low", cnt2, 4);
    check("stall_out_held", ov0, 1);
    check("release_ready_still_low", rdy0, 0);
    step(0, 1'b1, 8'(64 + idx), 1'b1, acc);
    if (acc) idx++;
    check("release_ready_high", rdy0, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 1'b1, 8'(64 + idx), 1'b1, acc);
      if (acc) idx++;
    end
    drain(0);
    $display("stall: %0d words sent", idx);

    // "no" throughput: 8 words in 16 cycles, ready toggling
    idx = 0; cnt = 0;
    for (int j = 0; j < 16; j++) begin
      if (rdy1 === ((j % 2) == 0)) cnt++;
      step(1, (idx < 8), 8'(8'hC0 + idx), 1'b1, acc);
      if (acc) idx++;
    end
    check("no_accepts", idx, 8);
    check("no_ready_toggle", cnt, 16);
    check("no_outputs_16cyc", out1, 8);
    drain(1);
    $display("no-burst throughput: %0d words out", out1);

    // Random handshakes
    rand_run(0, 5000, 20000);
    rand_run(1, 3000, 16000);
    rand_run(2, 5000, 20000);

    // Asynchronous reset with two words buffered
    step(0, 1'b1, 8'hA5, 1'b0, acc);
    step(0, 1'b1, 8'h5A, 1'b0, acc);
    check("pre_reset_valid", ov0, 1);
    check("pre_reset_data", od0, 8'hA5);
    check("pre_reset_ready", rdy0, 0);
    v0 = 1'b0; rb0 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", ov0, 0);
    check("async_rst_data", od0, 0);
    check("async_rst_ready", rdy0, 0);
    q0.delete();
    acc0 = out0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rerelease_ready_low", rdy0, 0);
    @(negedge clk);
    check("rerelease_ready_high", rdy0, 1);
    check("rerelease_valid", ov0, 0);
    drain(0);
    $display("reset mid-stream done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
